// File: rtl/channel_triangle_apu.sv
// Triangle-wave channel: period timer, up/down step sequencer, linear and
// length counters, and a small register write port. Output is an unsigned level.
`timescale 1ns/1ps

module channel_triangle_apu #(
    parameter int unsigned TIMER_WIDTH     = 11,
    parameter int unsigned STEP_BITS       = 5,
    parameter int unsigned OUT_WIDTH       = 4,
    parameter bit          MUTE_ULTRASONIC = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tick_stb,
    input  logic                 i_quarter_stb,
    input  logic                 i_half_stb,
    input  logic                 i_enable,
    input  logic                 i_wr_stb,
    input  logic [1:0]           i_wr_addr,
    input  logic [7:0]           i_wr_data,
    output logic [OUT_WIDTH-1:0] o_output,
    output logic                 o_active,
    output logic                 o_frame_pulse
);

    localparam int unsigned          Shift   = OUT_WIDTH - STEP_BITS + 1;
    localparam logic [STEP_BITS-1:0] StepMax = '1;

    logic [TIMER_WIDTH-1:0] period_q, period_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [STEP_BITS-1:0]   step_q, step_d;
    logic [6:0]             lin_q, lin_d;
    logic [6:0]             reload_val_q, reload_val_d;
    logic                   reload_flag_q, reload_flag_d;
    logic                   control_q, control_d;
    logic [7:0]             len_q, len_d;
    logic                   frame_pulse_q, frame_pulse_d;

    logic                   seq_clk;
    logic                   seq_gate;
    logic                   ultrasonic;
    logic [STEP_BITS-2:0]   level;

    function automatic logic [7:0] len_lookup(input logic [4:0] idx);
        logic [7:0] v;
        unique case (idx)
            5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
            5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
            5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
            5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
            5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
            5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
            5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
            5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   default: v = 8'd30;
        endcase
        return v;
    endfunction

    // Next-state: strobes act on pre-write state, register writes layered on top.
    always_comb begin
        period_d      = period_q;
        timer_d       = timer_q;
        step_d        = step_q;
        lin_d         = lin_q;
        reload_val_d  = reload_val_q;
        reload_flag_d = reload_flag_q;
        control_d     = control_q;
        len_d         = len_q;
        frame_pulse_d = 1'b0;

        ultrasonic = MUTE_ULTRASONIC && (period_q < TIMER_WIDTH'(2));
        seq_clk    = i_tick_stb && (timer_q == '0);
        seq_gate   = (lin_q != '0) && (len_q != '0) && !ultrasonic;

        if (i_tick_stb) begin
            timer_d = seq_clk ? period_q : timer_q - TIMER_WIDTH'(1);
        end

        if (seq_clk && seq_gate) begin
            step_d        = step_q + STEP_BITS'(1);
            frame_pulse_d = (step_q == StepMax);
        end

        if (i_quarter_stb) begin
            if (reload_flag_q) begin
                lin_d = reload_val_q;
            end else if (lin_q != '0) begin
                lin_d = lin_q - 7'd1;
            end
            if (!control_q) begin
                reload_flag_d = 1'b0;
            end
        end

        // Control doubles as the length-counter halt.
        if (i_half_stb && (len_q != '0) && !control_q) begin
            len_d = len_q - 8'd1;
        end

        if (i_wr_stb) begin
            unique case (i_wr_addr)
                2'd0: begin
                    control_d    = i_wr_data[7];
                    reload_val_d = i_wr_data[6:0];
                end
                2'd2: period_d[7:0] = i_wr_data;
                2'd3: begin
                    period_d[TIMER_WIDTH-1:8] = i_wr_data[TIMER_WIDTH-9:0];
                    reload_flag_d             = 1'b1;
                    if (i_enable) begin
                        len_d = len_lookup(i_wr_data[7:3]);
                    end
                end
                default: ;
            endcase
        end

        if (!i_enable) begin
            len_d = '0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            period_q      <= '0;
            timer_q       <= '0;
            step_q        <= '0;
            lin_q         <= '0;
            reload_val_q  <= '0;
            reload_flag_q <= 1'b0;
            control_q     <= 1'b0;
            len_q         <= '0;
            frame_pulse_q <= 1'b0;
        end else begin
            period_q      <= period_d;
            timer_q       <= timer_d;
            step_q        <= step_d;
            lin_q         <= lin_d;
            reload_val_q  <= reload_val_d;
            reload_flag_q <= reload_flag_d;
            control_q     <= control_d;
            len_q         <= len_d;
            frame_pulse_q <= frame_pulse_d;
        end
    end

    // Fold the step counter into a down-then-up ramp.
    always_comb begin
        level = step_q[STEP_BITS-1] ? step_q[STEP_BITS-2:0] : ~step_q[STEP_BITS-2:0];
    end

    assign o_output      = OUT_WIDTH'(level) << Shift;
    assign o_active      = (len_q != '0);
    assign o_frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_channel_triangle_apu.sv
// Bench for channel_triangle_apu: integer reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps

module tb_channel_triangle_apu;

    localparam int TW    = 11;
    localparam int SB    = 5;
    localparam int OW    = 4;
    localparam int NSTEP = 1 << SB;
    localparam int SHIFT = OW - SB + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick, qs, hs, en, wr;
    logic [1:0]    addr;
    logic [7:0]    data;
    logic [OW-1:0] out0, out1;
    logic          act0, act1, fp0, fp1;

    always #5 clk = ~clk;

    channel_triangle_apu #(.TIMER_WIDTH(TW), .STEP_BITS(SB), .OUT_WIDTH(OW),
                           .MUTE_ULTRASONIC(1'b0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick_stb(tick), .i_quarter_stb(qs),
        .i_half_stb(hs), .i_enable(en), .i_wr_stb(wr), .i_wr_addr(addr),
        .i_wr_data(data), .o_output(out0), .o_active(act0), .o_frame_pulse(fp0)
    );

    channel_triangle_apu #(.TIMER_WIDTH(TW), .STEP_BITS(SB), .OUT_WIDTH(OW),
                           .MUTE_ULTRASONIC(1'b1)) dut_m (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick_stb(tick), .i_quarter_stb(qs),
        .i_half_stb(hs), .i_enable(en), .i_wr_stb(wr), .i_wr_addr(addr),
        .i_wr_data(data), .o_output(out1), .o_active(act1), .o_frame_pulse(fp1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int len_tbl[32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                        12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};
    int seq_tbl[32] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0,
                        0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};

    // Model state, index 0 = normal instance, 1 = ultrasonic-mute instance.
    int m_period[2], m_timer[2], m_step[2], m_lin[2], m_rel[2];
    int m_flag[2], m_ctrl[2], m_len[2], m_fp[2];

    function automatic void check(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endfunction

    // Expected output level for a given step: ramp down through the first half, up through the second.
    function automatic int exp_level(input int s);
        int half;
        int lvl;
        half = NSTEP / 2;
        lvl  = (s < half) ? (half - 1 - s) : (s - half);
        return lvl * (1 << SHIFT);
    endfunction

    function automatic void model_reset(input int k);
        m_period[k] = 0; m_timer[k] = 0; m_step[k] = 0; m_lin[k] = 0; m_rel[k] = 0;
        m_flag[k] = 0; m_ctrl[k] = 0; m_len[k] = 0; m_fp[k] = 0;
    endfunction

    function automatic void model_step(input int k);
        bit clk_seq, gate;
        int d;
        d       = int'(data);
        clk_seq = tick && (m_timer[k] == 0);
        gate    = (m_lin[k] != 0) && (m_len[k] != 0) && !((k == 1) && (m_period[k] < 2));
        m_fp[k] = 0;
        if (clk_seq && gate) begin
            m_fp[k]   = (m_step[k] == NSTEP - 1);
            m_step[k] = (m_step[k] + 1) % NSTEP;
        end
        if (tick) m_timer[k] = (m_timer[k] == 0) ? m_period[k] : m_timer[k] - 1;
        if (qs) begin
            if (m_flag[k] != 0) m_lin[k] = m_rel[k];
            else if (m_lin[k] > 0) m_lin[k] = m_lin[k] - 1;
            if (m_ctrl[k] == 0) m_flag[k] = 0;
        end
        if (hs && m_len[k] > 0 && m_ctrl[k] == 0) m_len[k] = m_len[k] - 1;
        if (wr) begin
            if (addr == 2'd0) begin
                m_ctrl[k] = d / 128;
                m_rel[k]  = d % 128;
            end else if (addr == 2'd2) begin
                m_period[k] = (m_period[k] / 256) * 256 + d;
            end else if (addr == 2'd3) begin
                m_period[k] = (m_period[k] % 256) + (d % (1 << (TW - 8))) * 256;
                m_flag[k]   = 1;
                if (en) m_len[k] = len_tbl[d / 8];
            end
        end
        if (!en) m_len[k] = 0;
    endfunction

    // Advance the model on each edge, then compare both instances just after it.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) model_reset(k);
            else model_step(k);
        end
        #1;
        check("out0", int'(out0), exp_level(m_step[0]));
        check("act0", int'(act0), int'(m_len[0] != 0));
        check("fp0",  int'(fp0),  m_fp[0]);
        check("out1", int'(out1), exp_level(m_step[1]));
        check("act1", int'(act1), int'(m_len[1] != 0));
        check("fp1",  int'(fp1),  m_fp[1]);
    end

    task automatic cyc(input bit t, input bit q, input bit h, input bit w,
                       input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        tick = t; qs = q; hs = h; wr = w; addr = a; data = d;
    endtask

    task automatic wreg(input logic [1:0] a, input logic [7:0] d);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    endtask

    task automatic settle;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        tick = 0; qs = 0; hs = 0; wr = 0; addr = 0; data = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    int fpc;
    int tick_no;

    initial begin
        rst_n = 1'b0; en = 1'b1;
        tick = 0; qs = 0; hs = 0; wr = 0; addr = 0; data = 0;
        #1;
        check("rst_out", int'(out0), 15);
        check("rst_act", int'(act0), 0);
        check("rst_fp",  int'(fp0),  0);
        do_reset();

        // Free-running sequence, period 3 -> one step per 4 ticks.
        wreg(2'd0, 8'h81); wreg(2'd2, 8'h03); wreg(2'd3, 8'h08);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
        settle();
        check("s1_start_out", int'(out0), 15);
        check("s1_active", int'(act0), 1);
        fpc = 0;
        for (tick_no = 1; tick_no <= 128; tick_no++) begin
            ticks(1);
            settle();
            if (fp0) fpc++;
            if (tick_no % 4 == 1)
                check("s1_seq", int'(out0), seq_tbl[((tick_no - 1) / 4 + 1) % 32]);
        end
        check("s1_frame_pulses", fpc, 1);
        check("s1_active_end", int'(act0), 1);

        // Walk to level 7, then yank reset mid-cycle.
        ticks(28);
        ticks(1);
        settle();
        check("s6_level7", int'(out0), 7);
        #1 rst_n = 1'b0;
        #1;
        check("s6_rst_out", int'(out0), 15);
        check("s6_rst_act", int'(act0), 0);
        check("s6_rst_fp",  int'(fp0),  0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        @(negedge clk) rst_n = 1'b1;
        ticks(20);
        settle();
        check("s6_no_advance", int'(out0), 15);
        check("s6_inactive", int'(act0), 0);

        // Linear counter runs out -> freeze at last level.
        do_reset();
        wreg(2'd0, 8'h02); wreg(2'd2, 8'h03); wreg(2'd3, 8'h08);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
        ticks(5);
        settle();
        check("s2_out13", int'(out0), 13);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
        ticks(40);
        settle();
        check("s2_frozen", int'(out0), 13);
        check("s2_active", int'(act0), 1);

        // Length counter of 2 expires after two half strobes.
        do_reset();
        wreg(2'd0, 8'h7F); wreg(2'd2, 8'h03); wreg(2'd3, 8'h18);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
        ticks(1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
        settle();
        check("s3_after_h1", int'(act0), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
        settle();
        check("s3_after_h2", int'(act0), 0);
        ticks(20);
        settle();
        check("s3_frozen", int'(out0), 14);

        // Halt bit holds the length counter.
        do_reset();
        wreg(2'd0, 8'hFF); wreg(2'd2, 8'h03); wreg(2'd3, 8'h18);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
        settle();
        check("s3_halted", int'(act0), 1);

        // Enable drop clears the length counter and blocks loads.
        do_reset();
        wreg(2'd0, 8'h81); wreg(2'd3, 8'h08);
        settle();
        check("s4_loaded", int'(act0), 1);
        en = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        settle();
        check("s4_disabled", int'(act0), 0);
        wreg(2'd3, 8'h08);
        settle();
        check("s4_no_load", int'(act0), 0);
        en = 1'b1;

        // Ultrasonic mute: period 1 holds, period 2 steps every 3 ticks.
        do_reset();
        wreg(2'd0, 8'h81); wreg(2'd2, 8'h01); wreg(2'd3, 8'h08);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
        ticks(20);
        settle();
        check("s5_mute_hold", int'(out1), 15);
        check("s5_nomute_p1", int'(out0), 5);
        wreg(2'd2, 8'h02);
        ticks(30);
        settle();
        check("s5_mute_p2", int'(out1), 5);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 1999) != 0);
            tick  = ($urandom_range(0, 1) == 1);
            qs    = ($urandom_range(0, 15) == 0);
            hs    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) en = ~en;
            wr    = ($urandom_range(0, 9) == 0);
            addr  = 2'($urandom_range(0, 3));
            data  = 8'($urandom_range(0, 255));
            if (addr == 2'd2) data = 8'($urandom_range(0, 7));
            if (addr == 2'd3 && $urandom_range(0, 3) != 0) data = data & 8'hF8;
        end
        @(negedge clk);
        tick = 0; qs = 0; hs = 0; wr = 0;
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/channel_triangle_apu.md
Name: channel_triangle_apu

Overview:
- Parametrised triangle-wave channel, successor to the free-running phase-accumulator triangle.
- Adds NES-APU-style control:
  - programmable period timer
  - 2^STEP_BITS-step up/down sequencer
  - linear counter and length counter
  - register write port
- Sits between the register/sequencer bus and the mixer. Output is an unsigned level; the frame sequencer supplies i_quarter_stb and i_half_stb.

Parameters:
- TIMER_WIDTH, 11, timer period width; legal range 9..11.
- STEP_BITS, 5, sequencer step counter width (32 steps); legal range 2..6.
- OUT_WIDTH, 4, output level width; must be >= STEP_BITS-1.
- MUTE_ULTRASONIC, 0, when 1 the sequencer halts while period < 2.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tick_stb  in  1  one-cycle timer clock enable (CPU-rate tick).
- i_quarter_stb  in  1  one-cycle quarter-frame strobe; clocks the linear counter.
- i_half_stb  in  1  one-cycle half-frame strobe; clocks the length counter.
- i_enable  in  1  channel enable (status register bit).
- i_wr_stb  in  1  one-cycle register write strobe.
- i_wr_addr  in  2  register select.
- i_wr_data  in  8  write data.
- o_output  out  OUT_WIDTH  triangle level.
- o_active  out  1  high while length counter != 0.
- o_frame_pulse  out  1  one-cycle pulse when sequencer wraps from last step to 0.

Behaviour:
- Reset (async, i_rst_n=0):
  - All state cleared: period, timer, step, linear counter, reload value, reload flag, control bit, length counter.
  - Outputs: o_output = (2^(STEP_BITS-1)-1) << (OUT_WIDTH-STEP_BITS+1) (15 at defaults); o_active=0; o_frame_pulse=0.
  - Release is synchronous to the next edge.
- Register writes (i_wr_stb=1), taking effect at that clock edge:
  - addr0: control = data[7]; linear reload value = data[6:0].
  - addr1: ignored.
  - addr2: period[7:0] = data.
  - addr3: period[TIMER_WIDTH-1:8] = data[TIMER_WIDTH-9:0]; reload flag set. If i_enable=1, length counter = LEN_TABLE[data[7:3]].
- LEN_TABLE (index 0..31): 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Timer, on i_tick_stb:
  - If timer == 0: timer <= period and the sequencer-clock condition is evaluated.
  - Otherwise timer decrements.
  - A period write never alters the running timer; the new period is used at the next reload.
- Sequencer:
  - Advances step = step+1 (mod 2^STEP_BITS) on a timer reload only when linear counter != 0 AND length counter != 0 AND NOT (MUTE_ULTRASONIC && period < 2). Otherwise it holds, and the output holds its last level (no snap to 0).
  - o_frame_pulse is high for exactly the cycle after the step register goes from 2^STEP_BITS-1 to 0.
- Output mapping, with lo = step[STEP_BITS-2:0] and hi = step[STEP_BITS-1]:
  - level = hi ? lo : ~lo.
  - o_output = level << (OUT_WIDTH-STEP_BITS+1).
  - Combinational from the step register; zero-cycle latency after the step update.
  - Sequence at defaults: 15,14..0,0,1..15.
- Linear counter, on i_quarter_stb:
  - If reload flag: counter = reload value.
  - Else if counter != 0: counter decrements.
  - Then, if control = 0, the reload flag clears.
- Length counter, on i_half_stb: decrements when counter != 0 and control = 0 (halt). Never wraps below 0.
- i_enable = 0 forces the length counter to 0 every cycle. Addr3 writes do not load while disabled.
- o_active = (length counter != 0), registered state, no extra latency.
- Simultaneous events:
  - Addr3 write with i_half_stb in the same cycle: the load wins.
  - Addr3 write with i_quarter_stb: the flag set by the write applies from the next quarter strobe. The current strobe uses the prior flag value.
  - Addr0 write with i_quarter_stb: the strobe uses the old control and reload value.
  - i_tick_stb with any write: timer and sequencer evaluated with the pre-write register values.
- Mid-operation reset: immediate return to reset values regardless of strobes.

Test Plan:
- Reset, then write addr0=0x81, addr2=0x03, addr3=0x08 (len idx1=254), i_enable=1, one i_quarter_stb, then ticks every cycle → step advances every 4 ticks. o_output sequence 15,14..0,0,1..15. o_frame_pulse exactly once per 128 ticks. o_active=1.
- Same setup with addr0=0x02 (control=0, reload 2), four i_quarter_stb → linear counter 2,1,0. The sequencer freezes with o_output holding its last value, and o_active stays 1.
- Addr0=0x00, addr3 with len idx3 (=2), then two i_half_stb → o_active falls after the 2nd strobe and the output freezes. Repeat with control=1 → o_active stays 1.
- Drop i_enable with length 254 → o_active=0 the next cycle. Addr3 write while disabled → o_active stays 0.
- MUTE_ULTRASONIC=1, period=1 → step never changes. Period=2 → advances every 3 ticks.
- Assert i_rst_n=0 mid-sequence at output level 7 → immediately o_output=15, o_active=0, o_frame_pulse=0. After release, no advance until registers are rewritten.
